// File: rtl/conv_pkg.sv
// Shared definitions for the difference convolver and its inverse (deconv_accum).
// It holds the state encodings, the default sample width and the guard-bit width
// that the signed add needs to stay exact before clamping.
package conv_pkg;

    // One-hot state encodings. The idle state deliberately uses the top bit so
    // that a cleared register is not mistaken for a legal state.
    typedef enum logic [3:0] {
        ST_CLR  = 4'b1000,
        ST_IN   = 4'b0001,
        ST_CALC = 4'b0010,
        ST_OUT  = 4'b0100
    } conv_state_t;

    localparam int DEF_DATA_W  = 8;

    // An acc of DATA_W bits plus a diff of DATA_W+1 bits needs two extra bits
    // over DATA_W to hold every possible sum without wrapping.
    localparam int SUM_GUARD_W = 2;

    function automatic int sum_width(input int data_w);
        return data_w + SUM_GUARD_W;
    endfunction

endpackage

// File: rtl/sat_add_s.sv
// Signed saturating add: a DATA_W-bit accumulator plus a DATA_W+1-bit difference.
// The sum is formed exactly and then clamped to the DATA_W signed range. The sat
// output flags when the clamped result differs from the exact sum.
module sat_add_s
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W:0]   diff,
    output logic signed [DATA_W-1:0] result,
    output logic                     sat
);

    localparam int SUM_W = sum_width(DATA_W);

    // The limits are widened to the sum width so the signed compares need no
    // further extension.
    localparam logic signed [SUM_W-1:0] MAX_V = {{3{1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = {{3{1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [SUM_W-1:0] sum;

    // Exact sum of the sign-extended operands
    always_comb begin
        sum = {{2{acc[DATA_W-1]}}, acc} + {diff[DATA_W], diff};
    end

    // Clamp to the output range and flag any clamping
    always_comb begin
        result = sum[DATA_W-1:0];
        sat    = 1'b0;
        if (sum > MAX_V) begin
            result = MAX_V[DATA_W-1:0];
            sat    = 1'b1;
        end else if (sum < MIN_V) begin
            result = MIN_V[DATA_W-1:0];
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/deconv_accum.sv
// deconv_accum: rebuilds x[n] = x[n-1] + d[n] from signed difference samples.
// A saturating accumulator is seeded by DECONV_iStart, and each frame of LEN
// samples is emitted through a valid/ready handshake.
//
// state | meaning
// CLR   | idle; acc and count are zero and all outputs are low; waits for iStart
// IN    | oReady high; waits for a difference sample
// CALC  | accumulates the latched difference with clamping
// OUT   | presents the sample and holds it until iReady is high
//
// Every output is a register that is updated on the same edge as the state.
// This leaves no combinational path from iValid or iReady to any output.
module deconv_accum
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DECONV_iStart,
    input  logic [DATA_W-1:0] DECONV_iSeed,
    input  logic              DECONV_iValid,
    input  logic [DATA_W:0]   DECONV_iData,
    output logic              DECONV_oReady,
    input  logic              DECONV_iReady,
    output logic              DECONV_oValid,
    output logic [DATA_W-1:0] DECONV_oData,
    output logic              DECONV_oLast,
    output logic              DECONV_oSat,
    output logic              DECONV_oBusy
);

    localparam logic [7:0] LEN_C = 8'(LEN);

    conv_state_t              state;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W:0]   diff_q;
    logic [7:0]               count;

    logic signed [DATA_W-1:0] add_result;
    logic                     add_sat;

    logic                     ready_q;
    logic                     valid_q;
    logic                     last_q;
    logic                     sat_q;
    logic                     busy_q;
    logic [DATA_W-1:0]        data_q;

    sat_add_s #(
        .DATA_W (DATA_W)
    ) u_sat_add (
        .acc    (acc),
        .diff   (diff_q),
        .result (add_result),
        .sat    (add_sat)
    );

    // Sequencing FSM with the accumulator, the counter and the registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLR;
            acc     <= '0;
            diff_q  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state)
                ST_CLR: begin
                    if (DECONV_iStart) begin
                        acc     <= DECONV_iSeed;
                        count   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ST_IN;
                    end
                end
                ST_IN: begin
                    if (DECONV_iValid) begin
                        diff_q  <= DECONV_iData;
                        ready_q <= 1'b0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc     <= add_result;
                    count   <= count + 8'd1;
                    valid_q <= 1'b1;
                    data_q  <= add_result;
                    sat_q   <= add_sat;
                    last_q  <= ((count + 8'd1) == LEN_C);
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (DECONV_iReady) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        sat_q   <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            // Frame done: the accumulator does not carry into the next frame
                            acc    <= '0;
                            count  <= '0;
                            busy_q <= 1'b0;
                            state  <= ST_CLR;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= ST_IN;
                        end
                    end
                end
                default: begin
                    state   <= ST_CLR;
                    acc     <= '0;
                    count   <= '0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    sat_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign DECONV_oReady = ready_q;
    assign DECONV_oValid = valid_q;
    assign DECONV_oData  = data_q;
    assign DECONV_oLast  = last_q;
    assign DECONV_oSat   = sat_q;
    assign DECONV_oBusy  = busy_q;

endmodule

// File: tb/tb_deconv_accum.sv
// Directed bench for deconv_accum. The main instance uses LEN=8. A second LEN=1
// instance shares the same inputs, so every iStart that it takes in CLR produces
// a single-sample frame on its own outputs.
module tb_deconv_accum;

    logic              clk = 1'b0;
    logic              reset;
    logic              istart;
    logic [7:0]        iseed;
    logic              ivalid;
    logic [8:0]        idata;
    logic              iready;

    logic              o_ready, o_valid, o_last, o_sat, o_busy;
    logic signed [7:0] o_data;
    logic              l1_ready, l1_valid, l1_last, l1_sat, l1_busy;
    logic signed [7:0] l1_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    deconv_accum #(.DATA_W(8), .LEN(8)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .DECONV_iStart (istart),
        .DECONV_iSeed  (iseed),
        .DECONV_iValid (ivalid),
        .DECONV_iData  (idata),
        .DECONV_oReady (o_ready),
        .DECONV_iReady (iready),
        .DECONV_oValid (o_valid),
        .DECONV_oData  (o_data),
        .DECONV_oLast  (o_last),
        .DECONV_oSat   (o_sat),
        .DECONV_oBusy  (o_busy)
    );

    deconv_accum #(.DATA_W(8), .LEN(1)) u_dut_len1 (
        .clk           (clk),
        .reset         (reset),
        .DECONV_iStart (istart),
        .DECONV_iSeed  (iseed),
        .DECONV_iValid (ivalid),
        .DECONV_iData  (idata),
        .DECONV_oReady (l1_ready),
        .DECONV_iReady (iready),
        .DECONV_oValid (l1_valid),
        .DECONV_oData  (l1_data),
        .DECONV_oLast  (l1_last),
        .DECONV_oSat   (l1_sat),
        .DECONV_oBusy  (l1_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input int seed);
        istart = 1'b1;
        iseed  = 8'(seed);
        @(posedge clk);
        #1;
        istart = 1'b0;
        iseed  = 8'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // The task waits for oReady, offers one diff, checks that CALC holds oValid
    // low, and then checks the presented sample. It returns at the negedge in OUT.
    task automatic send_diff(input string tag, input int d, input int exp_data,
                             input int exp_sat, input int exp_last);
        int n = 0;
        while (o_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_rdy"}, int'(o_ready), 1);
        ivalid = 1'b1;
        idata  = 9'(d);
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        idata  = 9'd0;
        @(negedge clk);
        check({tag, "_calc_valid"}, int'(o_valid), 0);
        @(negedge clk);
        check({tag, "_valid"}, int'(o_valid), 1);
        check({tag, "_data"},  int'(o_data),  exp_data);
        check({tag, "_sat"},   int'(o_sat),   exp_sat);
        check({tag, "_last"},  int'(o_last),  exp_last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        istart = 1'b0;
        iseed  = 8'd0;
        ivalid = 1'b0;
        idata  = 9'd0;
        iready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(o_ready), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_data",  int'(o_data),  0);
        check("rst_busy",  int'(o_busy),  0);
        check("rst_last",  int'(o_last),  0);

        // Frame 1: seed 10, no saturation
        do_start(10);
        check("f1_busy", int'(o_busy), 1);
        send_diff("f1_s0", 5, 15, 0, 0);
        check("len1_f1_valid", int'(l1_valid), 1);
        check("len1_f1_data",  int'(l1_data),  15);
        check("len1_f1_last",  int'(l1_last),  1);
        send_diff("f1_s1", -3, 12, 0, 0);
        check("len1_f1_idle_valid", int'(l1_valid), 0);
        check("len1_f1_idle_busy",  int'(l1_busy),  0);
        send_diff("f1_s2", 0, 12, 0, 0);
        send_diff("f1_s3", 20, 32, 0, 0);
        send_diff("f1_s4", -40, -8, 0, 0);
        send_diff("f1_s5", 1, -7, 0, 0);
        send_diff("f1_s6", 1, -6, 0, 0);
        send_diff("f1_s7", 1, -5, 0, 1);
        @(negedge clk);
        check("f1_end_busy",  int'(o_busy),  0);
        check("f1_end_valid", int'(o_valid), 0);
        check("f1_end_ready", int'(o_ready), 0);
        check("f1_end_data",  int'(o_data),  0);

        // Positive clamp, then the next sample builds on the clamped value
        do_start(120);
        send_diff("f2_s0", 20, 127, 1, 0);
        check("len1_f2_data", int'(l1_data), 127);
        check("len1_f2_sat",  int'(l1_sat),  1);
        send_diff("f2_s1", -10, 117, 0, 0);
        do_reset();

        // Negative clamp with the most negative 9-bit diff
        do_start(-128);
        send_diff("f3_s0", -256, -128, 1, 0);
        check("len1_f3_data", int'(l1_data), -128);
        check("len1_f3_last", int'(l1_last), 1);
        do_reset();

        // Backpressure: the held sample stays stable and iValid pulses are ignored
        do_start(0);
        iready = 1'b0;
        send_diff("f4_s0", 3, 3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            ivalid = 1'b1;
            idata  = 9'd100;
            @(negedge clk);
            check("bp_valid", int'(o_valid), 1);
            check("bp_data",  int'(o_data),  3);
            check("bp_ready", int'(o_ready), 0);
        end
        ivalid = 1'b0;
        idata  = 9'd0;
        iready = 1'b1;
        send_diff("f4_s1", 4, 7, 0, 0);
        do_reset();

        // iStart mid-frame is ignored, then a reset mid-frame abandons the frame
        do_start(5);
        send_diff("f5_s0", 1, 6, 0, 0);
        send_diff("f5_s1", 1, 7, 0, 0);
        @(posedge clk);
        #1;
        do_start(50);
        send_diff("f5_s2", 1, 8, 0, 0);
        check("len1_f5_data", int'(l1_data), 51);
        check("len1_f5_last", int'(l1_last), 1);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_data",  int'(o_data),  0);
        check("mid_rst_last",  int'(o_last),  0);
        check("mid_rst_ready", int'(o_ready), 0);
        check("mid_rst_busy",  int'(o_busy),  0);
        ivalid = 1'b1;
        idata  = 9'd7;
        repeat (3) @(negedge clk);
        check("clr_ignore_valid", int'(o_valid), 0);
        check("clr_ignore_ready", int'(o_ready), 0);
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        idata  = 9'd0;
        do_start(0);
        send_diff("f6_s0", 1, 1, 0, 0);
        check("f6_busy",      int'(o_busy),  1);
        check("len1_f6_data", int'(l1_data), 1);
        check("len1_f6_last", int'(l1_last), 1);
        @(negedge clk);
        check("len1_f6_back_clr", int'(l1_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
